// File: rtl/lsu_ctrl_pkg.sv
// Shared types and helpers for the load-store unit front end.
// Provides funct3 size codes, FSM states and the natural-alignment check.
// Imported by mem_align and lsu_ctrl.
package lsu_ctrl_pkg;

    typedef enum logic [2:0] {
        MEM_B  = 3'b000,
        MEM_H  = 3'b001,
        MEM_W  = 3'b010,
        MEM_BU = 3'b100,
        MEM_HU = 3'b101
    } mem_size_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } lsu_ctrl_state_e;

    // Illegal funct3 codes behave as word accesses, so anything that is not
    // a byte or halfword code must be word aligned.
    function automatic logic is_misaligned(input logic [2:0] funct3,
                                           input logic [1:0] offset);
        logic mis;
        case (funct3)
            MEM_B, MEM_BU: mis = 1'b0;
            MEM_H, MEM_HU: mis = offset[0];
            default:       mis = (offset != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane steering: store lane replication + byte enables, load extract + sign/zero extension.
// Latency: purely combinational, zero cycles.
// Backpressure: none; ports: funct3/offset/st_data/ld_raw in, byte_en/st_lane_data/ld_data out.
module mem_align
    import lsu_ctrl_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] st_data,
    input  logic [31:0] ld_raw,
    output logic [3:0]  byte_en,
    output logic [31:0] st_lane_data,
    output logic [31:0] ld_data
);

    logic [31:0] byte_shift;
    logic [31:0] half_shift;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Halfword lanes only look at offset[1] and words ignore the offset, so a
    // misaligned access lands on its naturally aligned unit automatically.
    assign byte_shift = ld_raw >> {offset, 3'b000};
    assign half_shift = ld_raw >> {offset[1], 4'b0000};
    assign ld_byte    = byte_shift[7:0];
    assign ld_half    = half_shift[15:0];

    always_comb begin
        byte_en      = 4'b1111;
        st_lane_data = st_data;
        ld_data      = ld_raw;
        case (funct3)
            MEM_B: begin
                byte_en      = 4'b0001 << offset;
                st_lane_data = {4{st_data[7:0]}};
                ld_data      = {{24{ld_byte[7]}}, ld_byte};
            end
            MEM_BU: begin
                byte_en      = 4'b0001 << offset;
                st_lane_data = {4{st_data[7:0]}};
                ld_data      = {24'h0, ld_byte};
            end
            MEM_H: begin
                byte_en      = 4'b0011 << {offset[1], 1'b0};
                st_lane_data = {2{st_data[15:0]}};
                ld_data      = {{16{ld_half[15]}}, ld_half};
            end
            MEM_HU: begin
                byte_en      = 4'b0011 << {offset[1], 1'b0};
                st_lane_data = {2{st_data[15:0]}};
                ld_data      = {16'h0, ld_half};
            end
            default: begin
                byte_en      = 4'b1111;
                st_lane_data = st_data;
                ld_data      = ld_raw;
            end
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// LSU front end: accepts one RV32 memory op, strobes the LSU until valid, returns the extended result.
// Latency: accept -> REQ next cycle -> RESP one cycle after lsu_valid_i (>= 3 cycles/op, no overlap).
// Backpressure: req_ready_o only in IDLE; RESP holds until rsp_ready_i; watchdog aborts stuck REQ.
// Optional: define MISALIGN_TRAP_EN to trap misaligned H/W accesses instead of aligning them down.
module lsu_ctrl
    import lsu_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rstn_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_data_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_data_o,
    output logic        rsp_err_o,
    output logic        rsp_misaligned_o,
    output logic        lsu_read_o,
    output logic        lsu_write_o,
    output logic [3:0]  lsu_we_o,
    output logic [31:0] lsu_addr_o,
    output logic [31:0] lsu_data_o,
    input  logic [31:0] lsu_data_i,
    input  logic        lsu_valid_i
);

    localparam logic [CNT_W-1:0] TO_LAST =
        (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_ctrl_state_e state_q, state_d;

    logic             we_q;
    logic [2:0]       funct3_q;
    logic [31:0]      addr_q;
    logic [31:0]      sdata_q;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      rsp_data_q;
    logic             rsp_err_q;
    logic             rsp_mis_q;

    logic [3:0]       byte_en;
    logic [31:0]      st_lane_data;
    logic [31:0]      ld_data;
    logic             mis_trap;
    logic             timeout_hit;

`ifdef MISALIGN_TRAP_EN
    assign mis_trap = is_misaligned(req_funct3_i, req_addr_i[1:0]);
`else
    assign mis_trap = 1'b0;
`endif

    // Valid has priority: timeout only matters when no valid arrives this cycle.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST);

    mem_align u_align (
        .funct3       (funct3_q),
        .offset       (addr_q[1:0]),
        .st_data      (sdata_q),
        .ld_raw       (lsu_data_i),
        .byte_en      (byte_en),
        .st_lane_data (st_lane_data),
        .ld_data      (ld_data)
    );

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        req_ready_o      = 1'b0;
        rsp_valid_o      = 1'b0;
        lsu_read_o       = 1'b0;
        lsu_write_o      = 1'b0;
        lsu_we_o         = 4'b0000;
        lsu_addr_o       = 32'h0;
        lsu_data_o       = 32'h0;
        rsp_data_o       = rsp_data_q;
        rsp_err_o        = rsp_err_q;
        rsp_misaligned_o = rsp_mis_q;
        case (state_q)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    state_d = mis_trap ? RESP : REQ;
                end
            end
            REQ: begin
                lsu_read_o  = !we_q;
                lsu_write_o = we_q;
                lsu_addr_o  = {addr_q[31:2], 2'b00};
                if (we_q) begin
                    lsu_we_o   = byte_en;
                    lsu_data_o = st_lane_data;
                end
                if (lsu_valid_i || timeout_hit) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            we_q       <= 1'b0;
            funct3_q   <= 3'b000;
            addr_q     <= 32'h0;
            sdata_q    <= 32'h0;
            cnt_q      <= '0;
            rsp_data_q <= 32'h0;
            rsp_err_q  <= 1'b0;
            rsp_mis_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        we_q       <= req_we_i;
                        funct3_q   <= req_funct3_i;
                        addr_q     <= req_addr_i;
                        sdata_q    <= req_data_i;
                        cnt_q      <= '0;
                        rsp_data_q <= 32'h0;
                        rsp_err_q  <= 1'b0;
                        rsp_mis_q  <= mis_trap;
                    end
                end
                REQ: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (lsu_valid_i) begin
                        rsp_data_q <= we_q ? 32'h0 : ld_data;
                    end else if (timeout_hit) begin
                        rsp_err_q  <= 1'b1;
                        rsp_data_q <= 32'h0;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_data_q <= 32'h0;
                        rsp_err_q  <= 1'b0;
                        rsp_mis_q  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed cases plus randomized ops against a behavioural model.
// Inputs driven and outputs checked on the falling clock edge.
// Watchdog configured to 4 cycles so timeouts occur in the random mix.
module tb_lsu_ctrl;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rstn_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [2:0]  req_funct3_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_data_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_data_o;
    logic        rsp_err_o;
    logic        rsp_misaligned_o;
    logic        lsu_read_o;
    logic        lsu_write_o;
    logic [3:0]  lsu_we_o;
    logic [31:0] lsu_addr_o;
    logic [31:0] lsu_data_o;
    logic [31:0] lsu_data_i;
    logic        lsu_valid_i;

    int n_chk  = 0;
    int n_pass = 0;

    // Values observed from the most recent op, compared to literals afterwards.
    logic [3:0]  obs_be;
    logic [31:0] obs_addr;
    logic [31:0] obs_sd;
    logic [31:0] obs_rsp;
    logic        obs_err;
    logic        obs_mis;
    int          obs_strobe;
    int          obs_resp;

    lsu_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
        .clk              (clk),
        .rstn_i           (rstn_i),
        .req_valid_i      (req_valid_i),
        .req_ready_o      (req_ready_o),
        .req_we_i         (req_we_i),
        .req_funct3_i     (req_funct3_i),
        .req_addr_i       (req_addr_i),
        .req_data_i       (req_data_i),
        .rsp_valid_o      (rsp_valid_o),
        .rsp_ready_i      (rsp_ready_i),
        .rsp_data_o       (rsp_data_o),
        .rsp_err_o        (rsp_err_o),
        .rsp_misaligned_o (rsp_misaligned_o),
        .lsu_read_o       (lsu_read_o),
        .lsu_write_o      (lsu_write_o),
        .lsu_we_o         (lsu_we_o),
        .lsu_addr_o       (lsu_addr_o),
        .lsu_data_o       (lsu_data_o),
        .lsu_data_i       (lsu_data_i),
        .lsu_valid_i      (lsu_valid_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    function automatic int acc_bytes(input logic [2:0] f3);
        if (f3 == 3'd0 || f3 == 3'd4) return 1;
        if (f3 == 3'd1 || f3 == 3'd5) return 2;
        return 4;
    endfunction

    function automatic int aligned_off(input logic [2:0] f3, input logic [31:0] a);
        int o = int'(a[1:0]);
        return o - (o % acc_bytes(f3));
    endfunction

    function automatic logic [3:0] m_be(input logic we, input logic [2:0] f3, input logic [31:0] a);
        int m;
        if (!we) return 4'b0000;
        m = ((1 << acc_bytes(f3)) - 1) << aligned_off(f3, a);
        return m[3:0];
    endfunction

    function automatic logic [31:0] m_sd(input logic [2:0] f3, input logic [31:0] d);
        case (acc_bytes(f3))
            1:       return 32'(d[7:0]) * 32'h01010101;
            2:       return 32'(d[15:0]) * 32'h00010001;
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] m_ld(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] raw);
        int     s = acc_bytes(f3);
        longint v;
        if (s == 4) return raw;
        v = longint'(raw >> (8 * aligned_off(f3, a))) & ((64'd1 << (8 * s)) - 1);
        if ((f3 == 3'd0 || f3 == 3'd1) && v >= (64'd1 << (8 * s - 1))) v = v - (64'd1 << (8 * s));
        return v[31:0];
    endfunction

    function automatic logic m_mis(input logic [2:0] f3, input logic [31:0] a);
`ifdef MISALIGN_TRAP_EN
        return (int'(a[1:0]) % acc_bytes(f3)) != 0;
`else
        return 1'b0 & f3[0] & a[0];
`endif
    endfunction

    // ---------------- driver + per-cycle compare ----------------
    task automatic idle_chk();
        chk("idle_req_ready", req_ready_o, 1);
        chk("idle_rsp_valid", rsp_valid_o, 0);
        chk("idle_read", lsu_read_o, 0);
        chk("idle_write", lsu_write_o, 0);
        chk("idle_err", rsp_err_o, 0);
        chk("idle_mis", rsp_misaligned_o, 0);
    endtask

    // lat: REQ-cycle index on which lsu_valid_i is raised (>= TO means never).
    // hold: number of RESP cycles with rsp_ready_i low before the handshake.
    task automatic do_op(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d, input int lat, input int hold,
                         input logic [31:0] raw);
        logic        mis  = m_mis(f3, a);
        logic        tout = !mis && (lat >= TO);
        logic [31:0] rd   = (we || tout || mis) ? 32'h0 : m_ld(f3, a, raw);
        idle_chk();
        req_valid_i  = 1'b1;
        req_we_i     = we;
        req_funct3_i = f3;
        req_addr_i   = a;
        req_data_i   = d;
        rsp_ready_i  = 1'b0;
        lsu_valid_i  = 1'b0;
        obs_strobe   = 0;
        obs_resp     = 0;
        obs_be       = 4'h0;
        obs_addr     = 32'h0;
        obs_sd       = 32'h0;
        @(negedge clk);
        req_valid_i = 1'b0;
        req_addr_i  = $urandom;
        req_data_i  = $urandom;
        if (!mis) begin
            for (int i = 0; i < TO; i++) begin
                chk("req_ready_busy", req_ready_o, 0);
                chk("req_rsp_valid", rsp_valid_o, 0);
                chk("req_read", lsu_read_o, !we);
                chk("req_write", lsu_write_o, we);
                chk("req_we", lsu_we_o, m_be(we, f3, a));
                chk("req_addr", lsu_addr_o, {a[31:2], 2'b00});
                if (we) chk("req_sdata", lsu_data_o, m_sd(f3, d));
                if (i == 0) begin
                    obs_be   = lsu_we_o;
                    obs_addr = lsu_addr_o;
                    obs_sd   = lsu_data_o;
                end
                if (lsu_read_o || lsu_write_o) obs_strobe++;
                lsu_valid_i = (i == lat);
                lsu_data_i  = (i == lat) ? raw : $urandom;
                @(negedge clk);
                if (i == lat) break;
            end
            lsu_valid_i = 1'b0;
            lsu_data_i  = $urandom;
        end
        for (int j = 0; j <= hold; j++) begin
            chk("rsp_valid", rsp_valid_o, 1);
            chk("rsp_req_ready", req_ready_o, 0);
            chk("rsp_read", lsu_read_o, 0);
            chk("rsp_write", lsu_write_o, 0);
            chk("rsp_data", rsp_data_o, rd);
            chk("rsp_err", rsp_err_o, tout);
            chk("rsp_mis", rsp_misaligned_o, mis);
            if (j == 0) begin
                obs_rsp = rsp_data_o;
                obs_err = rsp_err_o;
                obs_mis = rsp_misaligned_o;
            end
            if (rsp_valid_o) obs_resp++;
            rsp_ready_i = (j == hold);
            @(negedge clk);
        end
        rsp_ready_i = 1'b0;
    endtask

    initial begin
        rstn_i       = 1'b0;
        req_valid_i  = 1'b0;
        req_we_i     = 1'b0;
        req_funct3_i = 3'b000;
        req_addr_i   = 32'h0;
        req_data_i   = 32'h0;
        rsp_ready_i  = 1'b0;
        lsu_data_i   = 32'h0;
        lsu_valid_i  = 1'b0;
        #12;
        chk("rst_req_ready", req_ready_o, 1);
        chk("rst_rsp_valid", rsp_valid_o, 0);
        chk("rst_read", lsu_read_o, 0);
        chk("rst_write", lsu_write_o, 0);
        chk("rst_we", lsu_we_o, 0);
        chk("rst_addr", lsu_addr_o, 0);
        chk("rst_rsp_data", rsp_data_o, 0);
        chk("rst_err", rsp_err_o, 0);
        chk("rst_mis", rsp_misaligned_o, 0);
        @(negedge clk);
        rstn_i = 1'b1;
        @(negedge clk);

        // SB to top lane, valid on third REQ cycle
        do_op(1'b1, 3'b000, 32'h0000_1003, 32'h0000_00A5, 2, 0, 32'hDEAD_BEEF);
        chk("sb_be_lit", obs_be, 32'h8);
        chk("sb_addr_lit", obs_addr, 32'h0000_1000);
        chk("sb_data_lit", obs_sd, 32'hA5A5_A5A5);
        chk("sb_strobe_cycles", obs_strobe, 3);
        chk("sb_rsp_lit", obs_rsp, 32'h0);

        do_op(1'b0, 3'b000, 32'h0000_2002, 32'h0, 0, 0, 32'h0080_FF00);
        chk("lb_lit", obs_rsp, 32'hFFFF_FF80);
        do_op(1'b0, 3'b100, 32'h0000_2002, 32'h0, 1, 0, 32'h0080_FF00);
        chk("lbu_lit", obs_rsp, 32'h0000_0080);
        do_op(1'b0, 3'b101, 32'h0000_2002, 32'h0, 0, 1, 32'h0080_FF00);
        chk("lhu_lit", obs_rsp, 32'h0000_0080);
        do_op(1'b0, 3'b001, 32'h0000_2000, 32'h0, 0, 0, 32'h0080_FF00);
        chk("lh_lit", obs_rsp, 32'hFFFF_FF00);

        // valid on the timeout cycle wins; response held for 4 cycles
        do_op(1'b0, 3'b010, 32'h0000_4000, 32'h0, TO - 1, 3, 32'h1234_5678);
        chk("lw_late_strobe", obs_strobe, 4);
        chk("lw_late_resp", obs_resp, 4);
        chk("lw_late_data", obs_rsp, 32'h1234_5678);
        chk("lw_late_err", obs_err, 0);

        // LSU never answers
        do_op(1'b0, 3'b010, 32'h0000_5000, 32'h0, 100, 0, 32'hFFFF_FFFF);
        chk("to_strobe", obs_strobe, 4);
        chk("to_err", obs_err, 1);
        chk("to_data", obs_rsp, 32'h0);
        do_op(1'b0, 3'b010, 32'h0000_5004, 32'h0, 1, 0, 32'hCAFE_F00D);
        chk("after_to_err", obs_err, 0);
        chk("after_to_data", obs_rsp, 32'hCAFE_F00D);

        do_op(1'b0, 3'b010, 32'h0000_3002, 32'h0, 0, 0, 32'h8765_4321);
`ifdef MISALIGN_TRAP_EN
        chk("mis_flag", obs_mis, 1);
        chk("mis_no_strobe", obs_strobe, 0);
        chk("mis_data", obs_rsp, 32'h0);
`else
        chk("mis_addr", obs_addr, 32'h0000_3000);
        chk("mis_we", obs_be, 0);
        chk("mis_flag", obs_mis, 0);
        chk("mis_data", obs_rsp, 32'h8765_4321);
`endif

        // reset in the middle of REQ
        idle_chk();
        req_valid_i  = 1'b1;
        req_we_i     = 1'b1;
        req_funct3_i = 3'b010;
        req_addr_i   = 32'h0000_6000;
        req_data_i   = 32'h1111_2222;
        @(negedge clk);
        req_valid_i = 1'b0;
        chk("pre_rst_write", lsu_write_o, 1);
        #2 rstn_i = 1'b0;
        #1;
        chk("mid_rst_write", lsu_write_o, 0);
        chk("mid_rst_read", lsu_read_o, 0);
        chk("mid_rst_rsp_valid", rsp_valid_o, 0);
        chk("mid_rst_req_ready", req_ready_o, 1);
        @(negedge clk);
        rstn_i = 1'b1;
        @(negedge clk);
        do_op(1'b0, 3'b010, 32'h0000_7000, 32'h0, 0, 0, 32'h0BAD_F00D);
        chk("post_rst_data", obs_rsp, 32'h0BAD_F00D);

        // randomized traffic
        for (int n = 0; n < 200; n++) begin
            int gap = $urandom_range(0, 2);
            do_op(1'($urandom), 3'($urandom), $urandom, $urandom,
                  $urandom_range(0, TO + 1), $urandom_range(0, 2), $urandom);
            for (int g = 0; g < gap; g++) begin
                idle_chk();
                @(negedge clk);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Pipeline-side front end for the load-store unit.
- Accepts one RV32 memory op (funct3-encoded LB/LH/LW/LBU/LHU/SB/SH/SW) per request handshake.
- Builds the word-aligned address, the byte-enable mask and the lane-shifted store data, and drives the LSU read/write strobes until the LSU signals valid.
- Extracts and sign/zero-extends load data, and returns the result to the pipeline with a response handshake and a bus-timeout watchdog.

Parameters:
- TIMEOUT_CYCLES, 64: maximum cycles in REQ before abort; 0 disables the watchdog.
- CNT_W, 8: watchdog counter width; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock
- rstn_i  in  1  asynchronous active-low reset
- req_valid_i  in  1  pipeline request valid
- req_ready_o  out  1  request accepted when high with req_valid_i
- req_we_i  in  1  1=store, 0=load
- req_funct3_i  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr_i  in  32  byte address
- req_data_i  in  32  store data, LSB-aligned
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  pipeline consumes response
- rsp_data_o  out  32  extended load data; 0 for stores/errors
- rsp_err_o  out  1  watchdog timeout
- rsp_misaligned_o  out  1  misaligned access (see Optional Feature)
- lsu_read_o  out  1  to LSU read_i
- lsu_write_o  out  1  to LSU write_i
- lsu_we_o  out  4  byte enables to LSU we_i
- lsu_addr_o  out  32  {addr[31:2],2'b00}
- lsu_data_o  out  32  store data shifted to byte lane
- lsu_data_i  in  32  LSU load data
- lsu_valid_i  in  1  LSU valid_o

Behaviour:
- Reset (async, rstn_i low): state IDLE. All outputs 0 except req_ready_o=1. All request registers and the counter are cleared.
- State IDLE:
  - req_ready_o=1.
  - On req_valid_i: register we, funct3, addr, data; clear counter; go to REQ.
  - Under MISALIGN_TRAP_EN, a misaligned request goes directly to RESP with rsp_misaligned_o=1.
- State REQ:
  - Exactly one of lsu_read_o/lsu_write_o is high, held stable with lsu_we_o/lsu_addr_o/lsu_data_o driven from the registers.
  - lsu_read_o and lsu_write_o are never both high.
  - On lsu_valid_i: capture the extended load result (stores capture 0) and go to RESP. The strobe drops the next cycle.
  - Counter increments each REQ cycle. If TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES-1 without valid: go to RESP with rsp_err_o=1, rsp_data_o=0.
  - lsu_valid_i and timeout in the same cycle: valid wins, no error.
- State RESP:
  - rsp_valid_o=1; LSU strobes low. This guarantees at least one idle cycle, so the LSU units reset between ops.
  - rsp_* outputs stay stable until rsp_ready_i, then go to IDLE and clear rsp_err_o/rsp_misaligned_o.
- Latency: accept at cycle 0, REQ from cycle 1, rsp_valid_o one cycle after lsu_valid_i. Minimum 3 cycles per op; no overlap between requests.
- Byte lanes (o = addr[1:0]):
  - B: we = 4'b0001<<o; data = {4{d[7:0]}}.
  - H: we = 4'b0011<<(o[1]*2); data = {2{d[15:0]}}.
  - W: we = 4'b1111; data = d.
  - Loads drive lsu_we_o=0.
- Load extract:
  - Byte = lsu_data_i>>(8*o), halfword >>(16*o[1]).
  - Sign-extend for 000/001; zero-extend for 100/101.
- Illegal funct3 (011, 110, 111): treated as W for the access; for loads the data is not extended.

Optional Feature:
- MISALIGN_TRAP_EN defined: H with addr[0]=1, or W with addr[1:0]!=0, performs no LSU access. The block goes to RESP in the cycle after accept with rsp_misaligned_o=1, rsp_data_o=0.
- Not defined: offending low address bits are forced to 0 (access goes to the naturally aligned unit) and rsp_misaligned_o is tied 0.

Decomposition:
- Package lsu_ctrl_pkg:
  - typedef enum mem_size_e for the funct3 codes.
  - typedef enum lsu_ctrl_state_e {IDLE, REQ, RESP}.
  - Function for the misalignment check.
- Sub-module mem_align (purely combinational): store lane shift + byte-enable generation, and load extract + extension. Instantiated once; the FSM and watchdog stay in lsu_ctrl.

Test Plan:
- SB addr 0x1003 data 0x000000A5 -> lsu_we_o=4'b1000, lsu_addr_o=0x1000, lsu_data_o=0xA5A5A5A5, lsu_write_o held until lsu_valid_i; rsp_data_o=0.
- LB addr 0x2002, lsu_data_i=0x0080FF00 -> rsp_data_o=0xFFFFFF80; LBU same -> 0x00000080; LHU addr 0x2002 -> 0x00000080.
- LW with lsu_valid_i delayed 5 cycles, rsp_ready_i low 3 cycles -> strobe high exactly 5 cycles, rsp_valid_o/rsp_data_o stable 4 cycles, req_ready_o low throughout.
- TIMEOUT_CYCLES=4, LSU never valid -> strobe drops after 4 REQ cycles, rsp_err_o=1, rsp_data_o=0; the next LW completes normally with rsp_err_o=0.
- LW addr 0x3002: with MISALIGN_TRAP_EN -> no strobe, rsp_misaligned_o=1 the cycle after accept; without -> lsu_addr_o=0x3000, we=0, rsp_misaligned_o=0.
- rstn_i pulsed low during REQ -> lsu_read_o/lsu_write_o/rsp_valid_o go to 0 immediately, req_ready_o=1; a fresh request is then accepted.
